// File: rtl/oped_axil_regfile_if.sv
// AXI4-Lite bus bundle between the OPED control-plane master and its register slaves.
interface oped_axil_regfile_if;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/oped_axil_regfile.sv
// AXI4-Lite register bank: ID, free-running cycle counter, byte-writable control and scratch words.
module oped_axil_regfile #(
   parameter int          NUM_REGS  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ID_VALUE  = 32'h4F50_4544
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   oped_axil_regfile_if.slave    s_axi,
   output logic [31:0]           CTRL
);
   localparam int          IDXW = $clog2(NUM_REGS);
   localparam logic [31:0] SPAN = 32'(4 * NUM_REGS);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   logic        rdy_q, rdy_d;
   logic        aw_held_q, aw_held_d;
   logic [31:0] awaddr_q, awaddr_d;
   logic        w_held_q, w_held_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        rvalid_q, rvalid_d;
   logic [1:0]  rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] regs_q [2:NUM_REGS-1];
   logic [31:0] regs_d [2:NUM_REGS-1];

   logic            aw_hs, w_hs, ar_hs, commit;
   logic [31:0]     wr_addr, wr_data, wr_off, rd_off, rd_mux;
   logic [3:0]      wr_strb;
   logic            wr_in, rd_in;
   logic [IDXW-1:0] wr_idx, rd_idx;
   logic            unused_bits;

   // rdy_q keeps all readies low for the first cycle out of reset.
   assign s_axi.awready = rdy_q & ~aw_held_q & ~bvalid_q;
   assign s_axi.wready  = rdy_q & ~w_held_q & ~bvalid_q;
   assign s_axi.arready = rdy_q & ~rvalid_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;
   assign CTRL          = regs_q[2];

   assign aw_hs  = s_axi.awvalid & s_axi.awready;
   assign w_hs   = s_axi.wvalid & s_axi.wready;
   assign ar_hs  = s_axi.arvalid & s_axi.arready;
   assign commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);

   assign wr_addr = aw_held_q ? awaddr_q : s_axi.awaddr;
   assign wr_data = w_held_q ? wdata_q : s_axi.wdata;
   assign wr_strb = w_held_q ? wstrb_q : s_axi.wstrb;
   // Unsigned subtraction makes addresses below the base wrap high and fail the span test.
   assign wr_off  = wr_addr - BASE_ADDR;
   assign rd_off  = s_axi.araddr - BASE_ADDR;
   assign wr_in   = wr_off < SPAN;
   assign rd_in   = rd_off < SPAN;
   assign wr_idx  = wr_off[IDXW+1:2];
   assign rd_idx  = rd_off[IDXW+1:2];

   assign unused_bits = ^{s_axi.awprot, s_axi.arprot, wr_off[1:0], rd_off[1:0]};

   always_comb begin
      rd_mux = 32'h0;
      if (rd_idx == IDXW'(0)) begin
         rd_mux = ID_VALUE;
      end else if (rd_idx == IDXW'(1)) begin
         rd_mux = cnt_q;
      end else begin
         for (int i = 2; i < NUM_REGS; i++) begin
            if (rd_idx == IDXW'(i)) rd_mux = regs_q[i];
         end
      end
   end

   always_comb begin
      rdy_d     = 1'b1;
      aw_held_d = aw_held_q;
      awaddr_d  = awaddr_q;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      cnt_d     = cnt_q + 32'd1;
      for (int i = 2; i < NUM_REGS; i++) regs_d[i] = regs_q[i];

      if (aw_hs) begin
         aw_held_d = 1'b1;
         awaddr_d  = s_axi.awaddr;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_axi.wdata;
         wstrb_d  = s_axi.wstrb;
      end
      if (bvalid_q && s_axi.bready) bvalid_d = 1'b0;
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_in ? RESP_OKAY : RESP_SLVERR;
         for (int i = 2; i < NUM_REGS; i++) begin
            for (int b = 0; b < 4; b++) begin
               if (wr_in && wr_idx == IDXW'(i) && wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end

      if (rvalid_q && s_axi.rready) rvalid_d = 1'b0;
      // Read samples pre-commit register contents, so a same-edge write is not visible.
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = rd_in ? RESP_OKAY : RESP_SLVERR;
         rdata_d  = rd_in ? rd_mux : 32'h0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rdy_q     <= 1'b0;
         aw_held_q <= 1'b0;
         awaddr_q  <= 32'h0;
         w_held_q  <= 1'b0;
         wdata_q   <= 32'h0;
         wstrb_q   <= 4'h0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= 32'h0;
         cnt_q     <= 32'h0;
         for (int i = 2; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
      end else begin
         rdy_q     <= rdy_d;
         aw_held_q <= aw_held_d;
         awaddr_q  <= awaddr_d;
         w_held_q  <= w_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         cnt_q     <= cnt_d;
         for (int i = 2; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
      end
   end
endmodule
